// File: rtl/mant_seq_divider_pkg.sv
// mant_seq_divider_pkg: divider state encoding and mantissa widths shared with the normalise/round stages
package mant_seq_divider_pkg;
    localparam int DP_MANT_W = 53;
    localparam int SP_MANT_W = 24;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;
endpackage

// File: rtl/mant_seq_divider_if.sv
// mant_seq_divider_if: operand request and result response handshakes of the mantissa divider
interface mant_seq_divider_if import mant_seq_divider_pkg::*; #(parameter int WIDTH = DP_MANT_W);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             sticky;
    logic             div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quot, rem, sticky, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quot, rem, sticky, div_by_zero
    );
endinterface

// File: rtl/mant_seq_divider_div_restoring_step.sv
// div_restoring_step: one radix-2 restoring iteration (shift in a dividend bit, subtract if it fits)
module div_restoring_step #(parameter int WIDTH = 53) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_nx,
    output logic             qbit
);
    logic [WIDTH+1:0] t;
    logic [WIDTH:0]   d;
    always_comb begin
        t    = {r, q_msb};
        d    = {1'b0, divisor};
        qbit = t >= {1'b0, d};
        r_nx = t[WIDTH:0] - (qbit ? d : '0);
    end
endmodule

// File: rtl/mant_seq_divider.sv
// mant_seq_divider: iterative restoring divider for unsigned mantissas, one quotient bit per clock
module mant_seq_divider import mant_seq_divider_pkg::*; #(parameter int WIDTH = DP_MANT_W) (
    input logic              clk,
    input logic              rst_n,
    mant_seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LD = CW'(WIDTH - 1);
    div_state_t       state, state_nx;
    logic [WIDTH:0]   r, r_nx;
    logic [WIDTH-1:0] q, dvs, quot_r, rem_r;
    logic [CW-1:0]    cnt;
    logic             qbit, dbz, ov, sticky_r, dbz_r, accept;
    assign bus.in_ready    = state == DIV_IDLE;
    assign bus.out_valid   = ov;
    assign bus.quot        = quot_r;
    assign bus.rem         = rem_r;
    assign bus.sticky      = sticky_r;
    assign bus.div_by_zero = dbz_r;
    always_comb begin
        accept   = rst_n && bus.in_valid && state == DIV_IDLE;
        state_nx = accept ? (bus.divisor == '0 ? DIV_DONE : DIV_CALC) :
                   (state == DIV_CALC && cnt == '0) ? DIV_DONE :
                   (state == DIV_DONE && ov && bus.out_ready) ? DIV_IDLE : state;
    end
    always_ff @(posedge clk)
        state <= !rst_n ? DIV_IDLE : state_nx;
    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q_msb   (q[WIDTH-1]),
        .divisor (dvs),
        .r_nx    (r_nx),
        .qbit    (qbit)
    );
    // divide-by-zero preloads the final answer so DONE can publish it unchanged
    always_ff @(posedge clk) begin
        if (accept) begin
            dbz <= bus.divisor == '0;
            dvs <= bus.divisor;
            cnt <= CNT_LD;
            r   <= bus.divisor == '0 ? {1'b0, bus.dividend} : '0;
            q   <= bus.divisor == '0 ? '1 : bus.dividend;
        end else if (state == DIV_CALC) begin
            r   <= r_nx;
            q   <= {q[WIDTH-2:0], qbit};
            cnt <= cnt - 1'b1;
        end
    end
    // results are captured on the first DONE cycle and frozen until consumed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov       <= 1'b0;
            quot_r   <= '0;
            rem_r    <= '0;
            sticky_r <= 1'b0;
            dbz_r    <= 1'b0;
        end else if (state == DIV_DONE) begin
            ov <= !(ov && bus.out_ready);
            if (!ov) begin
                quot_r   <= q;
                rem_r    <= r[WIDTH-1:0];
                sticky_r <= |r;
                dbz_r    <= dbz;
            end
        end
    end
endmodule

// File: tb/tb_mant_seq_divider.sv
// tb_mant_seq_divider: scoreboard bench for 8-bit and 53-bit divider instances
module tb_mant_seq_divider;
    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        s;
        logic        z;
    } exp_t;
    localparam logic [63:0] M53 = (64'd1 << 53) - 1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mant_seq_divider_if #(.WIDTH(8))  b8();
    mant_seq_divider_if #(.WIDTH(53)) b53();
    mant_seq_divider #(.WIDTH(8))  d8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    mant_seq_divider #(.WIDTH(53)) d53 (.clk(clk), .rst_n(rst_n), .bus(b53));
    exp_t sb8[$];
    exp_t sb53[$];
    exp_t e8, e53;
    int   vectors = 0;
    int   miscompares = 0;
    int   rdy_mode = 1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input bit wide, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic [63:0] m;
        m = wide ? M53 : 64'hFF;
        a = a & m;
        b = b & m;
        if (b == 0) begin
            e.q = m; e.r = a; e.s = a != 0; e.z = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.s = (a % b) != 0; e.z = 1'b0;
        end
        return e;
    endfunction
    // mode 0 stalls, 1 always ready, 2 random stalls
    always @(posedge clk) begin
        #1;
        b8.out_ready  = rdy_mode == 1 || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
        b53.out_ready = rdy_mode == 1 || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
    end
    always @(negedge clk)
        if (rst_n && b8.out_valid && b8.out_ready) begin
            if (sb8.size() == 0) check("spurious8", 1, 0);
            else begin
                e8 = sb8.pop_front();
                check("quot8", b8.quot, e8.q);
                check("rem8", b8.rem, e8.r);
                check("sticky8", b8.sticky, e8.s);
                check("dbz8", b8.div_by_zero, e8.z);
            end
        end
    always @(negedge clk)
        if (rst_n && b53.out_valid && b53.out_ready) begin
            if (sb53.size() == 0) check("spurious53", 1, 0);
            else begin
                e53 = sb53.pop_front();
                check("quot53", b53.quot, e53.q);
                check("rem53", b53.rem, e53.r);
                check("sticky53", b53.sticky, e53.s);
                check("dbz53", b53.div_by_zero, e53.z);
            end
        end
    task automatic issue(input bit wide, input logic [63:0] a, input logic [63:0] b,
                         input bit push, output int waits);
        @(posedge clk); #1;
        if (wide) begin
            b53.dividend = a[52:0]; b53.divisor = b[52:0]; b53.in_valid = 1'b1;
        end else begin
            b8.dividend = a[7:0]; b8.divisor = b[7:0]; b8.in_valid = 1'b1;
        end
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!(wide ? b53.in_ready : b8.in_ready) && waits < 500);
        if (!(wide ? b53.in_ready : b8.in_ready)) check("accept_timeout", 0, 1);
        else if (push) begin
            if (wide) sb53.push_back(model(1'b1, a, b));
            else sb8.push_back(model(1'b0, a, b));
        end
        @(posedge clk); #1;
        b8.in_valid   = 1'b0;
        b53.in_valid  = 1'b0;
        b8.dividend   = 8'($urandom);
        b8.divisor    = 8'($urandom);
        b53.dividend  = 53'({$urandom, $urandom});
        b53.divisor   = 53'({$urandom, $urandom});
    endtask
    task automatic wait_valid(input bit wide, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wide ? b53.out_valid : b8.out_valid) && n < 200);
    endtask
    task automatic drain();
        int n = 0;
        while ((sb8.size() != 0 || sb53.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb8.size() + sb53.size()), 0);
    endtask
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        int w, n;
        logic [63:0] a, b;
        b8.in_valid = 1'b1; b8.dividend = 8'd5; b8.divisor = 8'd9;
        b53.in_valid = 1'b0; b53.dividend = '0; b53.divisor = '0;
        b8.out_ready = 1'b1; b53.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", b8.in_ready, 1);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_quot", b8.quot, 0);
        check("rst_rem", b8.rem, 0);
        check("rst_sticky", b8.sticky, 0);
        check("rst_dbz", b8.div_by_zero, 0);
        check("rst_out_valid53", b53.out_valid, 0);
        b8.in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        issue(0, 200, 7, 1, w);
        wait_valid(0, n);
        check("lat_200_7", 64'(n - 1), 9);
        drain();
        issue(0, 17, 0, 1, w);
        wait_valid(0, n);
        check("lat_dbz", 64'(n - 1), 1);
        drain();
        issue(0, 255, 255, 1, w);
        issue(0, 5, 9, 1, w);
        issue(0, 0, 13, 1, w);
        issue(0, 77, 1, 1, w);
        issue(0, 0, 0, 1, w);
        drain();
        rdy_mode = 0;
        issue(0, 200, 7, 1, w);
        wait_valid(0, n);
        b8.in_valid = 1'b1; b8.dividend = 8'd9; b8.divisor = 8'd3;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", b8.out_valid, 1);
            check("bp_quot", b8.quot, 28);
            check("bp_rem", b8.rem, 4);
            check("bp_in_ready", b8.in_ready, 0);
        end
        rdy_mode = 1;
        issue(0, 9, 3, 1, w);
        check("bp_accept_wait", 64'(w), 2);
        drain();
        issue(0, 200, 7, 0, w);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", b8.out_valid, 0);
        check("rst_mid_ready", b8.in_ready, 1);
        issue(0, 100, 3, 1, w);
        drain();
        issue(1, 64'h1_2345_6789_ABCD, 64'h3_1415, 1, w);
        wait_valid(1, n);
        check("lat53", 64'(n - 1), 54);
        issue(1, M53, 1, 1, w);
        issue(1, M53, M53, 1, w);
        issue(1, 12345, M53, 1, w);
        issue(1, 0, 999, 1, w);
        issue(1, M53, 0, 1, w);
        issue(1, M53, 3, 1, w);
        drain();
        rdy_mode = 2;
        repeat (300) begin
            a = {$urandom, $urandom} & M53;
            b = ({$urandom, $urandom} & M53) >> $urandom_range(0, 52);
            if ($urandom_range(0, 31) == 0) b = 0;
            issue(1, a, b, 1, w);
        end
        repeat (400) issue(0, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1, w);
        drain();
        rdy_mode = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
